// File: rtl/challenge_210_core_if.sv
// Operand/result bundle for challenge_210_core; parity ports exist only when
// CHALLENGE_210_PARITY_EN is defined.
`timescale 1ns/1ps
interface challenge_210_core_if #(
    parameter int unsigned CNT_W = 8
);
    logic             aa;
    logic             bb;
    logic             cc;
    logic             yy;
    logic             yy_q;
    logic             yy_rise;
    logic             yy_fall;
    logic [CNT_W-1:0] toggle_cnt;
    logic             cnt_sat;
`ifdef CHALLENGE_210_PARITY_EN
    logic             par_q;
    logic             par_err;

    modport slave (
        input  aa, bb, cc,
        output yy, yy_q, yy_rise, yy_fall, toggle_cnt, cnt_sat, par_q, par_err
    );
    modport master (
        output aa, bb, cc,
        input  yy, yy_q, yy_rise, yy_fall, toggle_cnt, cnt_sat, par_q, par_err
    );
`else
    modport slave (
        input  aa, bb, cc,
        output yy, yy_q, yy_rise, yy_fall, toggle_cnt, cnt_sat
    );
    modport master (
        output aa, bb, cc,
        input  yy, yy_q, yy_rise, yy_fall, toggle_cnt, cnt_sat
    );
`endif
endinterface

// File: rtl/challenge_210_core.sv
// XOR of aa/bb with registered copy, edge pulses and saturating toggle counter.
// Optional macro CHALLENGE_210_PARITY_EN adds a registered parity self-check.
`timescale 1ns/1ps
module challenge_210_core #(
    parameter int unsigned CNT_W = 8
) (
    input logic                 clk,
    input logic                 rst,
    challenge_210_core_if.slave bus
);
    logic             yy_c;
    logic             yy_q_q, yy_q_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             unused_cc;

    always_comb begin
        yy_c = bus.aa ^ bus.bb;
        unused_cc = bus.cc;
    end

    always_comb begin
        yy_q_d = yy_c;
        rise_d = yy_c & ~yy_q_q;
        fall_d = ~yy_c & yy_q_q;
        cnt_d  = cnt_q;
        // Count only sampled transitions and hold at all-ones instead of wrapping.
        if ((yy_c != yy_q_q) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            yy_q_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            yy_q_q <= yy_q_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        bus.yy         = yy_c;
        bus.yy_q       = yy_q_q;
        bus.yy_rise    = rise_q;
        bus.yy_fall    = fall_q;
        bus.toggle_cnt = cnt_q;
        bus.cnt_sat    = &cnt_q;
    end

`ifdef CHALLENGE_210_PARITY_EN
    logic par_q_q, par_q_d;
    logic cc_q_q;
    logic err_q, err_d;

    always_comb begin
        par_q_d = bus.aa ^ bus.bb ^ bus.cc;
        // Registered parity must equal registered yy combined with registered cc.
        err_d   = err_q | (par_q_q != (yy_q_q ^ cc_q_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q_q <= 1'b0;
            cc_q_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            par_q_q <= par_q_d;
            cc_q_q  <= bus.cc;
            err_q   <= err_d;
        end
    end

    always_comb begin
        bus.par_q   = par_q_q;
        bus.par_err = err_q;
    end
`endif
endmodule

// File: tb/tb_challenge_210_core.sv
// Directed bench for challenge_210_core: default-width and CNT_W=3 instances.
`timescale 1ns/1ps
module tb_challenge_210_core;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    challenge_210_core_if #(.CNT_W(8)) bus_b ();
    challenge_210_core_if #(.CNT_W(3)) bus_s ();

    challenge_210_core #(.CNT_W(8)) u_big   (.clk(clk), .rst(rst), .bus(bus_b));
    challenge_210_core #(.CNT_W(3)) u_small (.clk(clk), .rst(rst), .bus(bus_s));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_in(input logic a, input logic b, input logic c);
        bus_b.aa = a; bus_b.bb = b; bus_b.cc = c;
        bus_s.aa = a; bus_s.bb = b; bus_s.cc = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_comb_sweep();
        logic [7:0] exp_tt;
        logic [2:0] v;
        exp_tt = 8'b0011_1100;
        rst = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            set_in(v[2], v[1], v[0]);
            #0.05;
            checks++;
            if (bus_b.yy !== exp_tt[i]) begin
                errors++;
                $display("FAIL comb_sweep[%0d] yy got %b expected %b", i, bus_b.yy, exp_tt[i]);
            end
        end
    endtask

    task automatic test_reset();
        set_in(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        checks++;
        if ({bus_b.yy_q, bus_b.yy_rise, bus_b.yy_fall, bus_b.cnt_sat} !== 4'b0000 ||
            bus_b.toggle_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_big got q/r/f/sat=%b%b%b%b cnt=%0d expected 0000 cnt=0",
                     bus_b.yy_q, bus_b.yy_rise, bus_b.yy_fall, bus_b.cnt_sat, bus_b.toggle_cnt);
        end
        checks++;
        if (bus_s.toggle_cnt !== 3'd0 || bus_s.cnt_sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_small got cnt=%0d sat=%b expected cnt=0 sat=0",
                     bus_s.toggle_cnt, bus_s.cnt_sat);
        end
    endtask

    task automatic test_first_rise();
        rst = 1'b0;
        set_in(1'b1, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus_b.yy_q !== 1'b1 || bus_b.yy_rise !== 1'b1 || bus_b.yy_fall !== 1'b0 ||
            bus_b.toggle_cnt !== 8'd1) begin
            errors++;
            $display("FAIL first_edge got q=%b rise=%b fall=%b cnt=%0d expected q=1 rise=1 fall=0 cnt=1",
                     bus_b.yy_q, bus_b.yy_rise, bus_b.yy_fall, bus_b.toggle_cnt);
        end
        tick();
        checks++;
        if (bus_b.yy_q !== 1'b1 || bus_b.yy_rise !== 1'b0 || bus_b.toggle_cnt !== 8'd1) begin
            errors++;
            $display("FAIL second_edge got q=%b rise=%b cnt=%0d expected q=1 rise=0 cnt=1",
                     bus_b.yy_q, bus_b.yy_rise, bus_b.toggle_cnt);
        end
    endtask

    task automatic test_alternate_and_saturate();
        logic exp_rise;
        set_in(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            set_in(logic'(i % 2), 1'b0, 1'b0);
            tick();
            exp_rise = logic'(i % 2);
            checks++;
            if (bus_b.yy_rise !== exp_rise || bus_b.yy_fall !== ~exp_rise ||
                bus_b.toggle_cnt !== 8'(i)) begin
                errors++;
                $display("FAIL alternate[%0d] got rise=%b fall=%b cnt=%0d expected rise=%b fall=%b cnt=%0d",
                         i, bus_b.yy_rise, bus_b.yy_fall, bus_b.toggle_cnt, exp_rise, ~exp_rise, i);
            end
            checks++;
            if (bus_s.toggle_cnt !== ((i < 7) ? 3'(i) : 3'd7) || bus_s.cnt_sat !== (i >= 7)) begin
                errors++;
                $display("FAIL saturate[%0d] got cnt=%0d sat=%b expected cnt=%0d sat=%b",
                         i, bus_s.toggle_cnt, bus_s.cnt_sat, (i < 7) ? i : 7, (i >= 7));
            end
        end
    endtask

    task automatic test_cc_only();
        set_in(1'b1, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 1'b1, logic'(~i[0]));
            #1;
            checks++;
            if (bus_b.yy !== 1'b0) begin
                errors++;
                $display("FAIL cc_only_yy[%0d] got %b expected 0", i, bus_b.yy);
            end
            tick();
            checks++;
            if (bus_b.yy_rise !== 1'b0 || bus_b.yy_fall !== 1'b0 || bus_b.toggle_cnt !== 8'd12 ||
                bus_s.toggle_cnt !== 3'd7) begin
                errors++;
                $display("FAIL cc_only[%0d] got rise=%b fall=%b cnt=%0d/%0d expected 0 0 12/7",
                         i, bus_b.yy_rise, bus_b.yy_fall, bus_b.toggle_cnt, bus_s.toggle_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        set_in(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            set_in(logic'(i % 2), 1'b0, logic'(i / 2 % 2));
            tick();
        end
        checks++;
        if (bus_b.toggle_cnt !== 8'd5 || bus_s.toggle_cnt !== 3'd5) begin
            errors++;
            $display("FAIL mid_count got %0d/%0d expected 5/5", bus_b.toggle_cnt, bus_s.toggle_cnt);
        end
        rst = 1'b1;
        set_in(1'b1, 1'b0, 1'b1);
        tick();
        checks++;
        if ({bus_b.yy_q, bus_b.yy_rise, bus_b.yy_fall} !== 3'b000 || bus_b.toggle_cnt !== 8'd0 ||
            bus_s.toggle_cnt !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset got q/r/f=%b%b%b cnt=%0d/%0d expected 000 0/0",
                     bus_b.yy_q, bus_b.yy_rise, bus_b.yy_fall, bus_b.toggle_cnt, bus_s.toggle_cnt);
        end
        checks++;
        if (bus_b.yy !== 1'b1) begin
            errors++;
            $display("FAIL yy_in_reset got %b expected 1", bus_b.yy);
        end
`ifdef CHALLENGE_210_PARITY_EN
        checks++;
        if (bus_b.par_q !== 1'b0 || bus_b.par_err !== 1'b0) begin
            errors++;
            $display("FAIL parity_reset got par_q=%b par_err=%b expected 0 0", bus_b.par_q, bus_b.par_err);
        end
`endif
        rst = 1'b0;
    endtask

`ifdef CHALLENGE_210_PARITY_EN
    task automatic test_parity();
        for (int i = 0; i < 8; i++) begin
            set_in(logic'(i / 4 % 2), logic'(i / 2 % 2), logic'(i % 2));
            tick();
            checks++;
            if (bus_b.par_q !== logic'((i / 4 + i / 2 + i) % 2) || bus_b.par_err !== 1'b0) begin
                errors++;
                $display("FAIL parity[%0d] got par_q=%b par_err=%b", i, bus_b.par_q, bus_b.par_err);
            end
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0);
        test_comb_sweep();
        test_reset();
        test_first_rise();
        test_alternate_and_saturate();
        test_cc_only();
        test_reset_mid();
`ifdef CHALLENGE_210_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
